contador_parametrico: RTL and testbench

Parametrised successor to the team's 4-bit enable/clear counter. Adds:
- configurable width and modulus
- up/down counting
- parallel load
- three terminal-count modes: wrap, saturate, one-shot
- cascade outputs (TC, WRAP)

Used as the general-purpose timer/counter primitive in the datapath and testbenches; multiple instances chain via TC into EN.

---
 rtl/contador_parametrico_pkg.sv | 16 +
 rtl/contador_parametrico.sv | 104 ++++++++++
 tb/tb_contador_parametrico.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/contador_parametrico_pkg.sv
// Shared constants for the parametric counter: terminal-count modes and the
// two-state run/done FSM encoding.
package contador_pkg;

  localparam int MODE_WRAP    = 0;
  localparam int MODE_SAT     = 1;
  localparam int MODE_ONESHOT = 2;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  function automatic bit mode_is_legal(input int mode);
    return (mode >= MODE_WRAP) && (mode <= MODE_ONESHOT);
  endfunction

endpackage

// File: rtl/contador_parametrico.sv
// General-purpose up/down counter with parallel load, configurable modulus and
// wrap / saturate / one-shot terminal behaviour. TC is combinational so that
// instances can be chained TC -> EN without losing a cycle.
module contador_parametrico
  import contador_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16,
  parameter int MODE    = 0
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             EN,
  input  logic             CLR,
  input  logic             LD,
  input  logic             UP,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             WRAP,
  output logic             DONE
);

  if ((MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_bad_modulus
    $error("contador_parametrico: MODULUS must lie in 2..2**WIDTH");
  end
  if (!mode_is_legal(MODE)) begin : g_bad_mode
    $error("contador_parametrico: MODE must be 0, 1 or 2");
  end

  // Compares and steps use one extra bit so MODULUS = 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0]   ONE_W = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

  // Out-of-range load values are clamped to the top of the count range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] din);
    if ({1'b0, din} < MOD_W) return din;
    else                     return MAX_Q;
  endfunction

  logic [WIDTH-1:0] q_q, q_d;
  logic [0:0]       state_q, state_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;     // previous edge was a saturated hold
  logic [WIDTH:0]   q_ext, term;
  logic             at_term, run;

  // Terminal detection, cascade output and next-state selection by priority.
  always_comb begin
    q_ext   = {1'b0, q_q};
    term    = UP ? MAX_W : '0;
    at_term = (q_ext == term);
    run     = (state_q == ST_RUN);
    TC      = EN & run & at_term;

    q_d     = q_q;
    state_d = state_q;
    wrap_d  = 1'b0;
    sat_d   = 1'b0;

    if (CLR) begin
      q_d     = '0;
      state_d = ST_RUN;
    end else if (LD) begin
      q_d     = clamp_load(D);
      state_d = ST_RUN;
    end else if (EN && run) begin
      if (!at_term) begin
        q_d = UP ? WIDTH'(q_ext + ONE_W) : WIDTH'(q_ext - ONE_W);
      end else if (MODE == MODE_WRAP) begin
        q_d    = UP ? '0 : MAX_Q;
        wrap_d = 1'b1;
      end else if (MODE == MODE_SAT) begin
        wrap_d = ~sat_q;
        sat_d  = 1'b1;
      end else begin
        state_d = ST_DONE;
        wrap_d  = 1'b1;
      end
    end
  end

  // Count register, FSM and event flags; reset overrides everything.
  always_ff @(posedge clk) begin
    if (RST) begin
      q_q     <= '0;
      state_q <= ST_RUN;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      q_q     <= q_d;
      state_q <= state_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  assign Q    = q_q;
  assign WRAP = wrap_q;
  assign DONE = (state_q == ST_DONE);

endmodule

// File: tb/tb_contador_parametrico.sv
// Bench for contador_parametrico: vector table, hand sequences for saturate and
// one-shot corners, randomized run against a reference model, and a cascade.
module tb_contador_parametrico;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, clr, ld, en, up;
  logic [3:0] d;
  logic [3:0] q_w [3];
  logic [2:0] tc_w, wrap_w, done_w;

  contador_parametrico #(.WIDTH(4), .MODULUS(10), .MODE(0)) dut_wrap (
    .clk(clk), .RST(rst), .EN(en), .CLR(clr), .LD(ld), .UP(up), .D(d),
    .Q(q_w[0]), .TC(tc_w[0]), .WRAP(wrap_w[0]), .DONE(done_w[0]));
  contador_parametrico #(.WIDTH(4), .MODULUS(10), .MODE(1)) dut_sat (
    .clk(clk), .RST(rst), .EN(en), .CLR(clr), .LD(ld), .UP(up), .D(d),
    .Q(q_w[1]), .TC(tc_w[1]), .WRAP(wrap_w[1]), .DONE(done_w[1]));
  contador_parametrico #(.WIDTH(4), .MODULUS(5), .MODE(2)) dut_one (
    .clk(clk), .RST(rst), .EN(en), .CLR(clr), .LD(ld), .UP(up), .D(d),
    .Q(q_w[2]), .TC(tc_w[2]), .WRAP(wrap_w[2]), .DONE(done_w[2]));

  logic       rst_c, en_c;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, hi_tc, lo_wrap, hi_wrap, lo_done, hi_done;

  contador_parametrico #(.WIDTH(4), .MODULUS(16), .MODE(0)) dut_lo (
    .clk(clk), .RST(rst_c), .EN(en_c), .CLR(1'b0), .LD(1'b0), .UP(1'b1), .D(4'd0),
    .Q(lo_q), .TC(lo_tc), .WRAP(lo_wrap), .DONE(lo_done));
  contador_parametrico #(.WIDTH(4), .MODULUS(16), .MODE(0)) dut_hi (
    .clk(clk), .RST(rst_c), .EN(lo_tc), .CLR(1'b0), .LD(1'b0), .UP(1'b1), .D(4'd0),
    .Q(hi_q), .TC(hi_tc), .WRAP(hi_wrap), .DONE(hi_done));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference model: one entry per mode instance, plain integer arithmetic.
  int mmod [3] = '{10, 10, 5};
  int mmode[3] = '{0, 1, 2};
  int mq   [3] = '{0, 0, 0};
  bit mdone[3] = '{0, 0, 0};
  bit mwrap[3] = '{0, 0, 0};
  bit mheld[3] = '{0, 0, 0};
  bit tc_s [3];

  function automatic bit model_tc(input int i, input bit e, input bit u);
    return e && !mdone[i] && (mq[i] == (u ? mmod[i] - 1 : 0));
  endfunction

  task automatic model_edge(input bit r, input bit c, input bit l, input bit e,
                            input bit u, input int dv);
    for (int i = 0; i < 3; i++) begin
      int m;
      bit at_end;
      m = mmod[i];
      at_end = (mq[i] == (u ? m - 1 : 0));
      mwrap[i] = 1'b0;
      if (r || c) begin
        mq[i] = 0; mdone[i] = 1'b0; mheld[i] = 1'b0;
      end else if (l) begin
        mq[i] = (dv < m) ? dv : m - 1; mdone[i] = 1'b0; mheld[i] = 1'b0;
      end else if (e && !mdone[i]) begin
        if (mmode[i] == 0) begin
          mq[i] = (mq[i] + (u ? 1 : -1) + m) % m;
          mwrap[i] = at_end;
          mheld[i] = 1'b0;
        end else if (!at_end) begin
          mq[i] = mq[i] + (u ? 1 : -1);
          mheld[i] = 1'b0;
        end else if (mmode[i] == 1) begin
          mwrap[i] = !mheld[i];
          mheld[i] = 1'b1;
        end else begin
          mdone[i] = 1'b1;
          mwrap[i] = 1'b1;
        end
      end else begin
        mheld[i] = 1'b0;
      end
    end
  endtask

  // One clock: drive, check TC mid-cycle, clock, check registered outputs.
  task automatic cyc(input bit r, input bit c, input bit l, input bit e,
                     input bit u, input int dv);
    rst = r; clr = c; ld = l; en = e; up = u; d = 4'(dv);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tc_s[i] = tc_w[i];
      chk($sformatf("model_tc[%0d]", i), int'(tc_w[i]), int'(model_tc(i, e, u)));
    end
    @(posedge clk);
    model_edge(r, c, l, e, u, dv);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_q[%0d]", i), int'(q_w[i]), mq[i]);
      chk($sformatf("model_wrap[%0d]", i), int'(wrap_w[i]), int'(mwrap[i]));
      chk($sformatf("model_done[%0d]", i), int'(done_w[i]), int'(mdone[i]));
    end
  endtask

  typedef struct {
    bit r, c, l, e, u;
    int d;
    bit tc;
    int q;
    bit wr;
  } vec_t;

  function automatic vec_t mkv(input bit r, input bit c, input bit l, input bit e,
                               input bit u, input int dv, input bit tc,
                               input int q, input bit wr);
    vec_t v;
    v.r = r; v.c = c; v.l = l; v.e = e; v.u = u; v.d = dv;
    v.tc = tc; v.q = q; v.wr = wr;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int exp_q1[6]  = '{8, 9, 9, 9, 8, 7};
    bit exp_w1[6]  = '{0, 0, 1, 0, 0, 0};
    bit up_1[6]    = '{1, 1, 1, 1, 0, 0};

    rst = 1'b1; clr = 1'b0; ld = 1'b0; en = 1'b0; up = 1'b1; d = 4'd0;
    rst_c = 1'b1; en_c = 1'b0;

    // Reset state
    cyc(1, 0, 0, 0, 1, 0);
    chk("reset_q", int'(q_w[0]), 0);
    chk("reset_done", int'(done_w[2]), 0);

    // Vector table for the MODULUS=10 wrap counter
    tbl.push_back(mkv(1, 0, 0, 1, 1, 0, 0, 0, 0));
    for (int k = 1; k <= 9; k++) tbl.push_back(mkv(0, 0, 0, 1, 1, 0, 0, k, 0));
    tbl.push_back(mkv(0, 0, 0, 1, 1, 0, 1, 0, 1));
    tbl.push_back(mkv(0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 1, 1, 0, 3, 1, 3, 0));
    tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 0, 2, 0));
    tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 1, 9, 1));
    tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 0, 8, 0));
    tbl.push_back(mkv(0, 0, 1, 0, 0, 12, 0, 9, 0));
    tbl.push_back(mkv(0, 1, 1, 0, 1, 6, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 1, 1, 1, 6, 0, 6, 0));
    tbl.push_back(mkv(1, 0, 1, 1, 1, 6, 0, 0, 0));
    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].c, tbl[i].l, tbl[i].e, tbl[i].u, tbl[i].d);
      chk($sformatf("vec%0d_tc", i), int'(tc_s[0]), int'(tbl[i].tc));
      chk($sformatf("vec%0d_q", i), int'(q_w[0]), tbl[i].q);
      chk($sformatf("vec%0d_wrap", i), int'(wrap_w[0]), int'(tbl[i].wr));
    end

    // Saturate: load 7, count up to 9 and hold, then reverse
    cyc(0, 0, 1, 0, 1, 7);
    chk("sat_load", int'(q_w[1]), 7);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 0, 0, 1, up_1[k], 0);
      chk($sformatf("sat%0d_q", k), int'(q_w[1]), exp_q1[k]);
      chk($sformatf("sat%0d_wrap", k), int'(wrap_w[1]), int'(exp_w1[k]));
    end

    // One-shot: count to 4, finish, ignore EN/UP, clear, resume, reset from done
    cyc(1, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 4; k++) cyc(0, 0, 0, 1, 1, 0);
    chk("one_q4", int'(q_w[2]), 4);
    chk("one_done_early", int'(done_w[2]), 0);
    cyc(0, 0, 0, 1, 1, 0);
    chk("one_done", int'(done_w[2]), 1);
    chk("one_wrap", int'(wrap_w[2]), 1);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("one_tc_in_done", int'(tc_s[2]), 0);
    chk("one_hold_q", int'(q_w[2]), 4);
    chk("one_hold_done", int'(done_w[2]), 1);
    cyc(0, 1, 0, 1, 1, 0);
    chk("one_clr_q", int'(q_w[2]), 0);
    chk("one_clr_done", int'(done_w[2]), 0);
    cyc(0, 0, 0, 1, 1, 0);
    chk("one_resume", int'(q_w[2]), 1);
    cyc(0, 0, 1, 0, 1, 4);
    cyc(0, 0, 0, 1, 1, 0);
    chk("one_done2", int'(done_w[2]), 1);
    cyc(1, 0, 0, 1, 1, 0);
    chk("one_rst_q", int'(q_w[2]), 0);
    chk("one_rst_done", int'(done_w[2]), 0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 4) != 0, int'($urandom_range(0, 15)));
    end

    // Cascade: low TC enables high, 8-bit count wraps back to 0x00 after 256
    rst_c = 1'b1; en_c = 1'b0;
    @(posedge clk); #1;
    chk("casc_reset", int'({hi_q, lo_q}), 0);
    rst_c = 1'b0; en_c = 1'b1;
    for (int n = 1; n <= 256; n++) begin
      @(negedge clk);
      chk("casc_lo_tc", int'(lo_tc), int'(((n - 1) % 16) == 15));
      chk("casc_hi_tc", int'(hi_tc), int'((n - 1) == 255));
      @(posedge clk); #1;
      chk("casc_lo_q", int'(lo_q), n % 16);
      chk("casc_hi_q", int'(hi_q), (n / 16) % 16);
      chk("casc_lo_wrap", int'(lo_wrap), int'((n % 16) == 0));
      chk("casc_hi_wrap", int'(hi_wrap), int'(n == 256));
    end
    chk("casc_final", int'({hi_q, lo_q}), 0);
    chk("casc_done", int'({hi_done, lo_done}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
